approx_rec_mul_seq: RTL and testbench

Sequential, parametrised successor to the team's combinational recursive 4x4-based multipliers. The block multiplies two W-bit unsigned operands by iterating over all (W/4)² 4-bit sub-products with a single shared 4x4 core, and accumulates them with the correct shifts. A per-transaction mode selects the sub-product source:
- exact;
- all-approximate (existing M2_4x4 cell);
- hybrid, where only low-significance sub-products are approximated.

It sits behind a valid/ready handshake in datapaths that trade area for latency.

---
 rtl/approx_mul_pkg.sv | 30 +++
 rtl/approx_rec_mul_seq_core4.sv | 48 ++++
 rtl/approx_rec_mul_seq.sv | 112 +++++++++++
 tb/tb_approx_rec_mul_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// Shared types for the sequential recursive multiplier: the chunk width, the
// per-transaction mode encoding and the FSM state encoding.
package approx_mul_pkg;

    localparam int CHUNK = 4;

    typedef enum logic [1:0] {
        MODE_EXACT  = 2'd0,
        MODE_APPROX = 2'd1,
        MODE_HYBRID = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Approximate 2x2 cell: exact except 3*3, which yields 7 instead of 9.
    function automatic logic [3:0] approx_mul2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] p;
        p = {2'b00, x} * {2'b00, y};
        if (x == 2'd3 && y == 2'd3) begin
            p = 4'd7;
        end
        return p;
    endfunction

endpackage

// File: rtl/approx_rec_mul_seq_core4.sv
// Shared 4x4 sub-product core: the M2_4x4 approximate cell, the exact product
// and the mux that picks between them for the current mode and significance.
module m2_4x4
    import approx_mul_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] ll;
    logic [3:0] lh;
    logic [3:0] hl;
    logic [3:0] hh;

    // Recursive composition from four approximate 2x2 cells.
    assign ll = approx_mul2(a[1:0], b[1:0]);
    assign lh = approx_mul2(a[1:0], b[3:2]);
    assign hl = approx_mul2(a[3:2], b[1:0]);
    assign hh = approx_mul2(a[3:2], b[3:2]);

    assign p = {4'b0000, ll} + ({4'b0000, lh} << 2) + ({4'b0000, hl} << 2) + {hh, 4'b0000};
endmodule

module approx_core4
    import approx_mul_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  mode_t      mode,
    input  logic       low_sig,
    output logic [7:0] pp
);
    logic [7:0] exact_p;
    logic [7:0] approx_p;
    logic       use_approx;

    m2_4x4 u_m2 (
        .a (x),
        .b (y),
        .p (approx_p)
    );

    assign exact_p = {4'b0000, x} * {4'b0000, y};

    // Reserved mode falls through to exact.
    assign use_approx = (mode == MODE_APPROX) || ((mode == MODE_HYBRID) && low_sig);
    assign pp         = use_approx ? approx_p : exact_p;
endmodule

// File: rtl/approx_rec_mul_seq.sv
// Sequential W x W multiplier that walks all (W/4)^2 4-bit sub-products through
// one shared 4x4 core and accumulates them, behind valid/ready handshakes.
module approx_rec_mul_seq
    import approx_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   y,
    output logic             busy,
    output state_t           dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, and y is held
    // unchanged in DONE until out_ready completes the transfer.
    localparam int N  = W / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    mode_t          mode_q;
    logic [IW-1:0]  i_q;
    logic [IW-1:0]  j_q;
    logic [2*W-1:0] acc;

    logic [IW:0]    ij_sum;
    logic           low_sig;
    logic           last_step;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [7:0]     pp;
    logic [2*W-1:0] pp_ext;
    logic [2*W-1:0] pp_sh;

    // i walks the multiplicand chunks fastest, j the multiplier chunks.
    assign ij_sum    = {1'b0, i_q} + {1'b0, j_q};
    assign low_sig   = ij_sum < (IW + 1)'(N);
    assign last_step = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));
    assign a_sh      = a_q >> {i_q, 2'b00};
    assign b_sh      = b_q >> {j_q, 2'b00};

    approx_core4 u_core (
        .x       (a_sh[3:0]),
        .y       (b_sh[3:0]),
        .mode    (mode_q),
        .low_sig (low_sig),
        .pp      (pp)
    );

    assign pp_ext = {{(2 * W - 8){1'b0}}, pp};
    assign pp_sh  = pp_ext << {ij_sum, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_EXACT;
            i_q    <= '0;
            j_q    <= '0;
            acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= mode_t'(mode);
                        i_q    <= '0;
                        j_q    <= '0;
                        acc    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc + pp_sh;
                    if (last_step) begin
                        i_q   <= '0;
                        j_q   <= '0;
                        state <= DONE;
                    end else if (i_q == IW'(N - 1)) begin
                        i_q <= '0;
                        j_q <= j_q + 1'b1;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign y         = acc;
    assign dbg_state = state;
endmodule

// File: tb/tb_approx_rec_mul_seq.sv
// Bench for approx_rec_mul_seq: a W=8 and a W=16 instance checked against a
// plain-arithmetic reference of the exact, approximate and hybrid products.
module tb_approx_rec_mul_seq;
    import approx_mul_pkg::*;

    logic clk;
    logic rst;

    logic        iv8, ir8, ov8, or8, bz8;
    logic [7:0]  a8, b8;
    logic [1:0]  m8;
    logic [15:0] y8;
    state_t      st8;

    logic        iv16, ir16, ov16, or16, bz16;
    logic [15:0] a16, b16;
    logic [1:0]  m16;
    logic [31:0] y16;
    state_t      st16;

    int n_checks;
    int n_fail;

    approx_rec_mul_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .mode(m8), .out_valid(ov8), .out_ready(or8), .y(y8), .busy(bz8),
        .dbg_state(st8)
    );

    approx_rec_mul_seq #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .mode(m16), .out_valid(ov16), .out_ready(or16), .y(y16), .busy(bz16),
        .dbg_state(st16)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // M2_4x4 equals the exact product minus 2 at weight 4^(p+q) for every pair
    // of 2-bit digits that are both 3.
    function automatic longint m2_ref(input longint x, input longint y);
        longint r;
        r = x * y;
        for (int p = 0; p < 2; p++)
            for (int q = 0; q < 2; q++)
                if (((x >> (2 * p)) & 3) == 3 && ((y >> (2 * q)) & 3) == 3)
                    r -= 2 << (2 * (p + q));
        return r;
    endfunction

    function automatic longint golden(input int w, input longint x, input longint y, input int md);
        longint sum;
        longint pp;
        int n;
        n = w / 4;
        sum = 0;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < n; i++) begin
                longint xi, yj;
                xi = (x >> (4 * i)) & 15;
                yj = (y >> (4 * j)) & 15;
                if (md == 1 || (md == 2 && i + j < n)) pp = m2_ref(xi, yj);
                else pp = xi * yj;
                sum += pp << (4 * (i + j));
            end
        end
        return sum & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // ---------------- driver tasks (start and end on a falling edge) ----------------
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        iv8 = 1'b1; a8 = a; b8 = b; m8 = m;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    task automatic wait8(output logic [15:0] y, output int lat);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        y = y8;
    endtask

    task automatic ack8();
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        output logic [15:0] y, output int lat);
        start8(a, b, m);
        wait8(y, lat);
        ack8();
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                         output logic [31:0] y, output int lat);
        iv16 = 1'b1; a16 = a; b16 = b; m16 = m;
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0;
        lat = 0;
        while (ov16 !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        y = y16;
        or16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or16 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0 || y8 !== 16'd0 || st8 !== IDLE) begin
            n_fail++;
            $display("FAIL reset8: in_ready=%b out_valid=%b busy=%b y=%0d state=%0d, want 1 0 0 0 0",
                     ir8, ov8, bz8, y8, st8);
        end
        n_checks++;
        if (ir16 !== 1'b1 || ov16 !== 1'b0 || bz16 !== 1'b0 || y16 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset16: in_ready=%b out_valid=%b busy=%b y=%0d, want 1 0 0 0",
                     ir16, ov16, bz16, y16);
        end
    endtask

    task automatic test_exact8();
        logic [15:0] y;
        int lat;
        run8(8'd200, 8'd150, 2'd0, y, lat);
        n_checks++;
        if (y !== 16'd30000) begin n_fail++; $display("FAIL exact8_200x150: y=%0d want 30000", y); end
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL latency8: edges=%0d want 4", lat); end
        run8(8'd255, 8'd255, 2'd0, y, lat);
        n_checks++;
        if (y !== 16'd65025) begin n_fail++; $display("FAIL exact8_255x255: y=%0d want 65025", y); end
        for (int k = 0; k < 20; k++) begin
            logic [7:0] a, b;
            a = 8'($urandom); b = 8'($urandom);
            run8(a, b, 2'd0, y, lat);
            n_checks++;
            if (y !== 16'(a * b)) begin n_fail++; $display("FAIL exact8_rand: %0d*%0d y=%0d want %0d", a, b, y, a * b); end
            run8(a, b, 2'd3, y, lat);
            n_checks++;
            if (y !== 16'(a * b)) begin n_fail++; $display("FAIL mode3_rand: %0d*%0d y=%0d want %0d", a, b, y, a * b); end
        end
    endtask

    task automatic test_exact16();
        logic [31:0] y;
        int lat;
        run16(16'hFFFF, 16'hFFFF, 2'd0, y, lat);
        n_checks++;
        if (y !== 32'hFFFE0001) begin n_fail++; $display("FAIL exact16_max: y=%h want fffe0001", y); end
        n_checks++;
        if (lat != 16) begin n_fail++; $display("FAIL latency16: edges=%0d want 16", lat); end
        for (int k = 0; k < 20; k++) begin
            logic [15:0] a, b;
            longint exp_v;
            a = 16'($urandom); b = 16'($urandom);
            exp_v = longint'(a) * longint'(b);
            run16(a, b, 2'd0, y, lat);
            n_checks++;
            if (y !== 32'(exp_v)) begin n_fail++; $display("FAIL exact16_rand: %h*%h y=%h want %h", a, b, y, 32'(exp_v)); end
        end
        for (int k = 0; k < 10; k++) begin
            logic [15:0] a, b;
            int md;
            a = 16'($urandom); b = 16'($urandom);
            md = $urandom_range(1, 2);
            run16(a, b, 2'(md), y, lat);
            n_checks++;
            if (y !== 32'(golden(16, a, b, md))) begin
                n_fail++;
                $display("FAIL approx16: mode=%0d %h*%h y=%h want %h", md, a, b, y, 32'(golden(16, a, b, md)));
            end
        end
    endtask

    task automatic test_approx8();
        logic [15:0] y;
        logic [15:0] exp_q[$];
        int lat;
        for (int k = 0; k < 1000; k++) begin
            logic [7:0] a, b;
            int md;
            a = 8'($urandom); b = 8'($urandom);
            md = (k % 2) + 1;
            exp_q.push_back(16'(golden(8, a, b, md)));
            run8(a, b, 2'(md), y, lat);
            n_checks++;
            if (y !== exp_q[0] || lat != 4) begin
                n_fail++;
                $display("FAIL approx8: mode=%0d %0d*%0d y=%0d lat=%0d want y=%0d lat=4", md, a, b, y, lat, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        // A pair where the two modes and exact all differ.
        run8(8'hFF, 8'hFF, 2'd1, y, lat);
        n_checks++;
        if (y !== 16'(golden(8, 255, 255, 1))) begin n_fail++; $display("FAIL approx8_max: y=%0d want %0d", y, golden(8, 255, 255, 1)); end
        run8(8'hFF, 8'hFF, 2'd2, y, lat);
        n_checks++;
        if (y !== 16'(golden(8, 255, 255, 2))) begin n_fail++; $display("FAIL hybrid8_max: y=%0d want %0d", y, golden(8, 255, 255, 2)); end
    endtask

    task automatic test_backpressure();
        logic [15:0] y;
        logic [15:0] exp_y;
        int lat;
        exp_y = 16'(golden(8, 173, 91, 2));
        start8(8'd173, 8'd91, 2'd2);
        wait8(y, lat);
        for (int k = 0; k < 5; k++) begin
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 2'd0;
            @(posedge clk);
            @(negedge clk);
            iv8 = 1'b0;
            n_checks++;
            if (y8 !== exp_y || ir8 !== 1'b0 || ov8 !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure: cycle=%0d y=%0d in_ready=%b out_valid=%b want y=%0d 0 1", k, y8, ir8, ov8, exp_y);
            end
        end
        or8 = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            n_fail++;
            $display("FAIL release: in_ready=%b out_valid=%b want 1 0", ir8, ov8);
        end
        @(negedge clk);
        or8 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (bz8 !== 1'b0 || st8 !== IDLE) begin
            n_fail++;
            $display("FAIL ignored_valid: busy=%b state=%0d want 0 0", bz8, st8);
        end
    endtask

    task automatic test_reset_run();
        logic [15:0] y;
        int lat;
        int spurious;
        start8(8'd100, 8'd77, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0 || y8 !== 16'd0 || st8 !== IDLE) begin
            n_fail++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b y=%0d state=%0d want 1 0 0 0 0",
                     ir8, ov8, bz8, y8, st8);
        end
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (ov8 !== 1'b0) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin n_fail++; $display("FAIL no_pulse_after_reset: out_valid cycles=%0d want 0", spurious); end
        run8(8'd3, 8'd5, 2'd0, y, lat);
        n_checks++;
        if (y !== 16'd15 || lat != 4) begin n_fail++; $display("FAIL after_reset: y=%0d lat=%0d want 15 4", y, lat); end
    endtask

    task automatic test_operand_change();
        logic [15:0] y;
        int lat;
        for (int k = 0; k < 5; k++) begin
            logic [7:0] a, b;
            a = 8'($urandom); b = 8'($urandom);
            start8(a, b, 2'd0);
            a8 = ~a; b8 = b ^ 8'h5A; m8 = 2'd1;
            wait8(y, lat);
            ack8();
            n_checks++;
            if (y !== 16'(a * b)) begin n_fail++; $display("FAIL operand_change: %0d*%0d y=%0d want %0d", a, b, y, a * b); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] y;
        int lat;
        run8(8'd17, 8'd19, 2'd0, y, lat);
        n_checks++;
        if (ir8 !== 1'b1) begin n_fail++; $display("FAIL in_ready_after_ack: in_ready=%b want 1", ir8); end
        iv8 = 1'b1; a8 = 8'd250; b8 = 8'd3; m8 = 2'd0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bz8 !== 1'b1 || st8 !== RUN) begin n_fail++; $display("FAIL next_accept: busy=%b state=%0d want 1 1", bz8, st8); end
        @(negedge clk);
        iv8 = 1'b0;
        wait8(y, lat);
        ack8();
        n_checks++;
        if (y !== 16'd750 || lat != 4) begin n_fail++; $display("FAIL back_to_back: y=%0d lat=%0d want 750 4", y, lat); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; m16 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_exact8();
        test_exact16();
        test_approx8();
        test_backpressure();
        test_reset_run();
        test_operand_change();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
